// File: rtl/ddr_pkg.sv
// ddr_pkg: shared DDR transaction type and default field widths.
package ddr_pkg;
   localparam int DDR_ADDR_W = 32;
   localparam int DDR_DATA_W = 64;
   typedef struct packed {
      logic                    is_write;
      logic [DDR_ADDR_W-1:0]   addr;
      logic [DDR_DATA_W-1:0]   wdata;
      logic [DDR_DATA_W/8-1:0] wmask;
   } ddr_txn_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy and status flags for a power-of-two FIFO.
module fifo_ptr_ctrl #(
   parameter int DEPTH = 8,
   parameter int AFULL_THRESH = 6,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          i_flush,
   input  logic          i_push_req,
   input  logic          i_pop_req,
   output logic          o_push,
   output logic [AW-1:0] o_wptr,
   output logic [AW-1:0] o_rptr,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_almost_full
);
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   assign o_full        = r_count == CW'(DEPTH);
   assign o_empty       = r_count == '0;
   assign o_almost_full = r_count >= CW'(AFULL_THRESH);
   // Acceptance depends only on registered state, so no in->ready combinational path.
   assign o_push        = i_push_req && !o_full;
   assign w_pop         = i_pop_req && !o_empty;
   assign o_wptr        = r_wptr;
   assign o_rptr        = r_rptr;
   assign o_count       = r_count;
   always_ff @(posedge clk) begin
      if (n_rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (o_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(o_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/ddr_txn_fifo.sv
// ddr_txn_fifo: show-ahead FIFO of DDR transactions between host and command scheduler.
module ddr_txn_fifo
   import ddr_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ADDR_W = DDR_ADDR_W,
   parameter int DATA_W = DDR_DATA_W,
   parameter int AFULL_THRESH = 6
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_is_write,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_wdata,
   input  logic [DATA_W/8-1:0]      in_wmask,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_is_write,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_wdata,
   output logic [DATA_W/8-1:0]      out_wmask,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     overflow_err
);
   localparam int AW = $clog2(DEPTH);
   ddr_txn_t      r_mem [DEPTH];
   ddr_txn_t      w_in_txn, w_head;
   logic          w_push;
   logic [AW-1:0] w_wptr, w_rptr;
   logic          r_overflow;
   fifo_ptr_ctrl #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL_THRESH)) u_ptr (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_flush      (flush),
      .i_push_req   (in_valid),
      .i_pop_req    (out_ready),
      .o_push       (w_push),
      .o_wptr       (w_wptr),
      .o_rptr       (w_rptr),
      .o_count      (count),
      .o_full       (full),
      .o_empty      (empty),
      .o_almost_full(almost_full)
   );
   assign w_in_txn     = '{is_write: in_is_write, addr: in_addr, wdata: in_wdata, wmask: in_wmask};
   // A write during flush lands in an entry the cleared pointers treat as free.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wptr] <= w_in_txn;
   end
   always_ff @(posedge clk) begin
      if (n_rst) r_overflow <= 1'b0;
      else if (in_valid && full) r_overflow <= 1'b1;
   end
   assign w_head       = empty ? '0 : r_mem[w_rptr];
   assign in_ready     = !full;
   assign out_valid    = !empty;
   assign out_is_write = w_head.is_write;
   assign out_addr     = w_head.addr;
   assign out_wdata    = w_head.wdata;
   assign out_wmask    = w_head.wmask;
   assign overflow_err = r_overflow;
endmodule

// File: tb/tb_ddr_txn_fifo.sv
// tb_ddr_txn_fifo: directed stimulus with a scoreboard queue checked by a separate pop monitor.
module tb_ddr_txn_fifo;
   import ddr_pkg::*;
   logic        clk = 0;
   logic        n_rst = 1;
   logic        in_valid = 0, in_ready, in_is_write = 0;
   logic [31:0] in_addr = 0;
   logic [63:0] in_wdata = 0;
   logic [7:0]  in_wmask = 0;
   logic        out_valid, out_ready = 0, out_is_write;
   logic [31:0] out_addr;
   logic [63:0] out_wdata;
   logic [7:0]  out_wmask;
   logic        flush = 0;
   logic [3:0]  count;
   logic        full, empty, almost_full, overflow_err;
   ddr_txn_t    q[$];
   int          n_cmp = 0, n_fail = 0, mc = 0;
   ddr_txn_fifo dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_is_write(in_is_write), .in_addr(in_addr), .in_wdata(in_wdata), .in_wmask(in_wmask),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_write(out_is_write),
      .out_addr(out_addr), .out_wdata(out_wdata), .out_wmask(out_wmask),
      .flush(flush), .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .overflow_err(overflow_err)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   // Scoreboard update at the edge; the monitor already consumed any pop at the preceding negedge.
   task automatic tick();
      bit p;
      bit o;
      ddr_txn_t e;
      @(posedge clk);
      if (n_rst || flush) begin
         q.delete();
         mc = 0;
      end else begin
         p = in_valid && mc < 8;
         o = out_ready && mc > 0;
         e = '{is_write: in_is_write, addr: in_addr, wdata: in_wdata, wmask: in_wmask};
         if (p) q.push_back(e);
         mc = mc + int'(p) - int'(o);
      end
      #1;
   endtask
   task automatic push(input logic [31:0] a, input logic [63:0] d);
      in_valid = 1; in_is_write = 0; in_addr = a; in_wdata = d; in_wmask = 8'h0F;
      tick();
      in_valid = 0;
   endtask
   always @(negedge clk) begin
      ddr_txn_t e;
      if (!n_rst && !flush && out_valid && out_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected @%0t: got addr %0h expected no entry", $time, out_addr);
         end else begin
            e = q.pop_front();
            if ({out_is_write, out_addr, out_wdata, out_wmask} !== e) begin
               n_fail++;
               $display("FAIL pop_data @%0t: got %b/%h/%h/%h expected %b/%h/%h/%h", $time,
                        out_is_write, out_addr, out_wdata, out_wmask, e.is_write, e.addr, e.wdata, e.wmask);
            end
         end
      end
   end
   task automatic chk_reset(input string s);
      chk({s, "_count"}, count, 0);
      chk({s, "_empty"}, empty, 1);
      chk({s, "_full"}, full, 0);
      chk({s, "_afull"}, almost_full, 0);
      chk({s, "_in_ready"}, in_ready, 1);
      chk({s, "_out_valid"}, out_valid, 0);
      chk({s, "_out_addr"}, out_addr, 0);
      chk({s, "_overflow"}, overflow_err, 0);
   endtask
   initial begin
      tick();
      tick();
      n_rst = 0;
      chk_reset("reset");
      in_valid = 1; in_is_write = 1; in_addr = 32'h1000;
      in_wdata = 64'hDEADBEEF_CAFEF00D; in_wmask = 8'hFF;
      tick();
      in_valid = 0;
      chk("single_valid", out_valid, 1);
      chk("single_count", count, 1);
      chk("single_we", out_is_write, 1);
      chk("single_addr", out_addr, 32'h1000);
      chk("single_wdata", out_wdata, 64'hDEADBEEF_CAFEF00D);
      chk("single_wmask", out_wmask, 8'hFF);
      out_ready = 1; tick(); out_ready = 0;
      chk("single_empty", empty, 1);
      for (int i = 0; i < 8; i++) begin
         push(32'(i * 64), 64'(i));
         if (i == 4) chk("afull_at5", almost_full, 0);
         if (i == 5) chk("afull_at6", almost_full, 1);
         if (i == 6) chk("full_at7", full, 0);
      end
      chk("fill_full", full, 1);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_count", count, 8);
      in_valid = 1; in_addr = 32'hBAD;
      tick(); tick();
      in_valid = 0;
      chk("ovf_set", overflow_err, 1);
      chk("ovf_count", count, 8);
      tick();
      chk("ovf_sticky", overflow_err, 1);
      out_ready = 1; repeat (3) tick(); out_ready = 0;
      chk("pop3_count", count, 5);
      for (int i = 0; i < 3; i++) push(32'h200 + 32'(i * 64), 64'h100 + 64'(i));
      chk("wrap_full", count, 8);
      in_valid = 1; in_addr = 32'h2C0; out_ready = 1;
      tick();
      in_valid = 0; out_ready = 0;
      chk("full_pushpop_count", count, 7);
      chk("full_pushpop_ready", in_ready, 1);
      out_ready = 1; repeat (3) tick(); out_ready = 0;
      chk("to4_count", count, 4);
      for (int i = 0; i < 6; i++) begin
         out_ready = 1;
         push(32'h300 + 32'(i * 64), 64'h200 + 64'(i));
         out_ready = 0;
         chk("pushpop4_count", count, 4);
      end
      out_ready = 1; repeat (4) tick(); out_ready = 0;
      chk("drain_empty", empty, 1);
      chk("drain_out_addr", out_addr, 0);
      for (int i = 0; i < 5; i++) push(32'h400 + 32'(i * 64), 64'h300 + 64'(i));
      chk("pre_flush_count", count, 5);
      in_valid = 1; in_addr = 32'h500; flush = 1;
      tick();
      in_valid = 0; flush = 0;
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_keeps_ovf", overflow_err, 1);
      push(32'h600, 64'h600);
      chk("post_flush_addr", out_addr, 32'h600);
      out_ready = 1; tick(); out_ready = 0;
      for (int i = 0; i < 3; i++) push(32'h700 + 32'(i * 64), 64'h700 + 64'(i));
      chk("pre_reset_count", count, 3);
      n_rst = 1; tick(); n_rst = 0;
      chk_reset("midreset");
      chk("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
